// File: rtl/echo_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// echo_cmd_sequencer
//
// Upstream sequencer for the shift-echo datapath unit. A request word is taken
// over a valid/ready channel and driven onto dp_data_in. dp_cmd then walks the
// unit through a load phase and a drive phase, each SETTLE_CYC cycles long
// (legal range 1..15). At the end of the drive phase the unit's Data_out bus is
// sampled and returned on the response channel.
//
// dp_cmd = {tag, phase}. phase 0 = load or bus released, 1 = drive. The tag
// advances on every accepted request, so the level-sensitive unit sees a new
// Command value on every phase, including back-to-back words.
//
// Valid/ready semantics (both channels): a word moves on a rising clk edge where
// valid and ready are both 1. A source holds valid and data steady until the
// transfer happens. req_ready is combinational and also rises in RESP when
// rsp_ready is high, so a response drain and the next request accept can share
// one edge.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   req_valid/ready   request handshake, req_data = word to echo
//   rsp_valid/ready   response handshake, rsp_data = sampled Data_out,
//                     rsp_ovf = request had a nonzero bit in its top three bits
//   busy              1 whenever the FSM is not IDLE
//   dp_data_in        to datapath Data_in, held from one accept to the next
//   dp_cmd            to datapath Command
//   dp_data_out       from datapath Data_out, meaningful only while dp_cmd[0]=1
//   dbg_state         current FSM state (IDLE=0, LOAD=1, DRIVE=2, RESP=3)
// -----------------------------------------------------------------------------
module echo_cmd_sequencer #(
  parameter int DATA_W     = 16,
  parameter int CMD_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              busy,
  output logic [DATA_W-1:0] dp_data_in,
  output logic [CMD_W-1:0]  dp_cmd,
  input  logic [DATA_W-1:0] dp_data_out,
  output logic [1:0]        dbg_state
);

  localparam int TAG_W = CMD_W - 1;
  // Terminal count of each phase; counter restarts at 0 on entry.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRIVE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    tag_d;
  logic [3:0]          cnt_q;
  logic [3:0]          cnt_d;
  logic [CMD_W-1:0]    dp_cmd_q;
  logic [DATA_W-1:0]   dp_data_in_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_ovf_q;
  logic                accept;
  logic                req_ovf;

  // Tag wraps naturally at 2^TAG_W; never equals the previous tag.
  assign tag_d   = tag_q + 1'b1;
  assign cnt_d   = cnt_q + 4'd1;
  assign req_ovf = |req_data[DATA_W-1:DATA_W-3];

  assign req_ready = (state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      cnt_q        <= '0;
      dp_cmd_q     <= '0;
      dp_data_in_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (cnt_q == CNT_LAST) begin
            dp_cmd_q <= {tag_q, 1'b1};
            cnt_q    <= '0;
            state_q  <= S_DRIVE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= dp_data_out;
            rsp_valid_q <= 1'b1;
            dp_cmd_q    <= {tag_q, 1'b0};
            cnt_q       <= '0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: ;
      endcase

      // Accept is only possible from IDLE or a draining RESP; placed last so
      // it overrides the RESP->IDLE move when both happen on one edge.
      if (accept) begin
        dp_data_in_q <= req_data;
        rsp_ovf_q    <= req_ovf;
        tag_q        <= tag_d;
        dp_cmd_q     <= {tag_d, 1'b0};
        cnt_q        <= '0;
        state_q      <= S_LOAD;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign dp_data_in = dp_data_in_q;
  assign dp_cmd     = dp_cmd_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_echo_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_echo_cmd_sequencer
//
// Three sequencers (SETTLE_CYC = 1, 2, 5) share one request/response stimulus
// stream. Each has its own shift-echo datapath model and its own reference
// model. The reference model tracks a transaction as "accepted at edge N"; all
// expected outputs come from how many edges have elapsed since then.
// Directed sections exercise the examples on the SETTLE_CYC=2 instance.
// -----------------------------------------------------------------------------
module tb_echo_cmd_sequencer;

  localparam int NI = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // shared stimulus
  logic        req_valid = 1'b0;
  logic [15:0] req_data  = '0;
  logic        rsp_ready = 1'b0;

  // per-instance outputs
  logic        req_ready_a  [NI];
  logic        rsp_valid_a  [NI];
  logic [15:0] rsp_data_a   [NI];
  logic        rsp_ovf_a    [NI];
  logic        busy_a       [NI];
  logic [15:0] dp_data_in_a [NI];
  logic [7:0]  dp_cmd_a     [NI];
  logic [15:0] dp_data_out_a[NI];
  logic [1:0]  dbg_state_a  [NI];

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int S = (k == 0) ? 1 : (k == 1) ? 2 : 5;

    echo_cmd_sequencer #(.DATA_W(16), .CMD_W(8), .SETTLE_CYC(S)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready_a[k]),
      .req_data   (req_data),
      .rsp_valid  (rsp_valid_a[k]),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data_a[k]),
      .rsp_ovf    (rsp_ovf_a[k]),
      .busy       (busy_a[k]),
      .dp_data_in (dp_data_in_a[k]),
      .dp_cmd     (dp_cmd_a[k]),
      .dp_data_out(dp_data_out_a[k]),
      .dbg_state  (dbg_state_a[k])
    );

    // Shift-echo unit: latches Data_in while phase=0, drives Data_in<<3 while
    // phase=1, bus otherwise floats (modelled as a junk pattern).
    logic [15:0] lat;
    always_latch if (!dp_cmd_a[k][0]) lat = dp_data_in_a[k];
    assign dp_data_out_a[k] = dp_cmd_a[k][0] ? (lat << 3) : 16'hDEAD;

    // reference model
    logic [16:0] exp_q[$];     // {ovf, data}
    bit          in_flight = 1'b0;
    int          acc_edge  = 0;
    int          tag_m     = 0;
    logic [15:0] last_data = '0;
    int          n_acc     = 0;

    always @(negedge clk) begin
      int    kk;
      bit    exp_rv;
      bit    exp_rdy;
      bit    ph;
      logic [15:0] sh;
      if (!reset_n) begin
        in_flight = 1'b0;
        tag_m     = 0;
        last_data = '0;
        exp_q.delete();
      end else begin
        kk      = cyc - acc_edge;
        exp_rv  = in_flight && (kk >= 2 * S);
        exp_rdy = !in_flight || (exp_rv && rsp_ready);
        ph      = in_flight && (kk >= S) && (kk < 2 * S);
        check($sformatf("rsp_valid[S=%0d]", S), 32'(rsp_valid_a[k]), 32'(exp_rv));
        check($sformatf("busy[S=%0d]", S), 32'(busy_a[k]), 32'(in_flight));
        check($sformatf("req_ready[S=%0d]", S), 32'(req_ready_a[k]), 32'(exp_rdy));
        check($sformatf("dp_cmd[S=%0d]", S), 32'(dp_cmd_a[k]), 32'(tag_m * 2 + int'(ph)));
        check($sformatf("dp_data_in[S=%0d]", S), 32'(dp_data_in_a[k]), 32'(last_data));
        if (exp_rv && exp_q.size() > 0)
          check($sformatf("rsp[S=%0d]", S), 32'({rsp_ovf_a[k], rsp_data_a[k]}), 32'(exp_q[0]));
        // effects of the coming edge
        if (exp_rv && rsp_ready) begin
          void'(exp_q.pop_front());
          in_flight = 1'b0;
        end
        if (req_valid && exp_rdy) begin
          sh = req_data * 16'd8;
          exp_q.push_back({(req_data >= 16'h2000), sh});
          in_flight = 1'b1;
          tag_m     = (tag_m + 1) % 128;
          acc_edge  = cyc + 1;
          last_data = req_data;
          n_acc++;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp1();
    int n = 0;
    while (!rsp_valid_a[1] && n < 40) begin
      tick();
      n++;
    end
    check("rsp_timeout", 32'(rsp_valid_a[1]), 32'd1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (15) tick();
  endtask

  initial begin
    int          n0 [NI];
    int          nb;
    logic [15:0] held;
    logic [15:0] d2;

    // reset
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("post_reset_ready", 32'(req_ready_a[1]), 32'd1);
    check("post_reset_busy",  32'(busy_a[1]),      32'd0);
    check("post_reset_cmd",   32'(dp_cmd_a[1]),    32'd0);

    // word 0x0123: Command 0x02 then 0x03, latency per instance
    rsp_ready = 1'b1;
    req_data  = 16'h0123;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t2_cmd_e0", 32'(dp_cmd_a[1]), 32'h02);
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("t2_rv_s1_e%0d", e), 32'(rsp_valid_a[0]), 32'(e == 2));
      check($sformatf("t2_rv_s2_e%0d", e), 32'(rsp_valid_a[1]), 32'(e == 4));
      check($sformatf("t2_rv_s5_e%0d", e), 32'(rsp_valid_a[2]), 32'(e == 10));
      if (e == 2) check("t2_cmd_e2", 32'(dp_cmd_a[1]), 32'h03);
      if (e == 2) check("t2_data_s1", 32'(rsp_data_a[0]), 32'h0918);
      if (e == 4) begin
        check("t2_data", 32'(rsp_data_a[1]), 32'h0918);
        check("t2_ovf",  32'(rsp_ovf_a[1]),  32'd0);
        check("t2_cmd_e4", 32'(dp_cmd_a[1]), 32'h02);
      end
      if (e == 10) check("t2_data_s5", 32'(rsp_data_a[2]), 32'h0918);
    end
    tick();

    // word 0xE001: top bits lost
    req_data  = 16'hE001;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp1();
    check("t3_data", 32'(rsp_data_a[1]), 32'h0008);
    check("t3_ovf",  32'(rsp_ovf_a[1]),  32'd1);
    drain();

    // response back-pressure with a request held
    rsp_ready = 1'b0;
    req_data  = 16'($urandom) | 16'h0001;
    req_valid = 1'b1;
    tick();
    wait_rsp1();
    held = rsp_data_a[1];
    repeat (10) begin
      tick();
      check("t4_ready_low", 32'(req_ready_a[1]), 32'd0);
      check("t4_hold",      32'(rsp_data_a[1]),  32'(held));
    end
    d2 = 16'($urandom) | 16'h0001;
    req_data  = d2;
    rsp_ready = 1'b1;
    #1;
    check("t4_ready_comb", 32'(req_ready_a[1]), 32'd1);
    tick();
    req_valid = 1'b0;
    check("t4_rv_drop", 32'(rsp_valid_a[1]),  32'd0);
    check("t4_busy",    32'(busy_a[1]),       32'd1);
    check("t4_din",     32'(dp_data_in_a[1]), 32'(d2));
    wait_rsp1();
    drain();

    // asynchronous reset in the middle of a transaction
    req_data  = 16'($urandom) | 16'h0001;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_rv",   32'(rsp_valid_a[1]),  32'd0);
    check("rst_data", 32'(rsp_data_a[1]),   32'd0);
    check("rst_ovf",  32'(rsp_ovf_a[1]),    32'd0);
    check("rst_busy", 32'(busy_a[1]),       32'd0);
    check("rst_cmd",  32'(dp_cmd_a[1]),     32'd0);
    check("rst_din",  32'(dp_data_in_a[1]), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_ready", 32'(req_ready_a[1]), 32'd1);
    check("rel_busy",  32'(busy_a[1]),      32'd0);

    // back-to-back: throughput and tag wrap
    nb = 700;
    n0[0] = g[0].n_acc;
    n0[1] = g[1].n_acc;
    n0[2] = g[2].n_acc;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    repeat (nb) begin
      req_data = 16'($urandom);
      tick();
    end
    check("b2b_s1", 32'(g[0].n_acc - n0[0]), 32'((nb + 2) / 3));
    check("b2b_s2", 32'(g[1].n_acc - n0[1]), 32'((nb + 4) / 5));
    check("b2b_s5", 32'(g[2].n_acc - n0[2]), 32'((nb + 10) / 11));
    drain();

    // random traffic
    repeat (3000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      req_data  = 16'($urandom);
      tick();
    end
    drain();
    check("end_idle_s2", 32'(busy_a[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
